// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: one write port, two read ports, bulk-clear request and status.
// The master drives the requests and the slave (the register file) returns read data and Busy.
interface regfile_param_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              RegWrite;
    logic [ADDR_W-1:0] WriteRegNo;
    logic [WIDTH-1:0]  WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              Clear;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic              Busy;

    modport master (
        output RegWrite, WriteRegNo, WriteData, ReadReg1, ReadReg2, Clear,
        input  ReadData1, ReadData2, Busy
    );

    modport slave (
        input  RegWrite, WriteRegNo, WriteData, ReadReg1, ReadReg2, Clear,
        output ReadData1, ReadData2, Busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: one write port, two registered read ports with write bypass,
// optional hardwired-zero r0 and a sequential bulk-clear sweep.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic Clock,
    input  logic Reset,
    regfile_param_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              sweeping;
    logic              wr_ok;
    logic [WIDTH-1:0]  rd1_p0, rd2_p0;
    logic [WIDTH-1:0]  rd1_p1, rd2_p1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Priority: unmapped/zero register, then the slot being swept, then a same-edge write.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored
    );
        if (!in_range(a) || is_zero_reg(a)) return '0;
        if (sweeping && (a == cnt))         return '0;
        if (wr_ok && (a == bus.WriteRegNo)) return bus.WriteData;
        return stored;
    endfunction

    assign sweeping = (state == SWEEP);
    assign wr_ok    = bus.RegWrite && !sweeping && in_range(bus.WriteRegNo)
                      && !is_zero_reg(bus.WriteRegNo);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.Clear) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                end
            end
            SWEEP: begin
                if (int'(cnt) == DEPTH - 1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Writes are locked out during a sweep, so the two update sources never collide.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (sweeping) begin
            regs[idx(cnt)] <= '0;
        end else if (wr_ok) begin
            regs[idx(bus.WriteRegNo)] <= bus.WriteData;
        end
    end

    always_comb begin
        rd1_p0 = read_sel(bus.ReadReg1, regs[idx(bus.ReadReg1)]);
        rd2_p0 = read_sel(bus.ReadReg2, regs[idx(bus.ReadReg2)]);
    end

    // Stage p1: registered read data
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rd1_p1 <= '0;
            rd2_p1 <= '0;
        end else begin
            rd1_p1 <= rd1_p0;
            rd2_p1 <= rd2_p0;
        end
    end

    assign bus.ReadData1 = rd1_p1;
    assign bus.ReadData2 = rd2_p1;
    assign bus.Busy      = sweeping;
endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: three builds (default, ZERO_REG=0, DEPTH=20) driven with
// directed vectors; expectations are queued at issue time and checked by an independent monitor.
module tb_regfile_param;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    regfile_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if0 ();
    regfile_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if1 ();
    regfile_param_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) if2 ();

    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1)) u_dut0 (
        .Clock(Clock), .Reset(Reset), .bus(if0));
    regfile_param #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(0)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .bus(if1));
    regfile_param #(.WIDTH(32), .DEPTH(20), .ADDR_W(5), .ZERO_REG(1)) u_dut2 (
        .Clock(Clock), .Reset(Reset), .bus(if2));

    typedef struct {
        int          dut;
        int          sig;
        logic [31:0] exp;
        int          due;
        int          tid;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int d, input int s);
        logic [31:0] v;
        v = '0;
        case (d)
            0: v = (s == 0) ? if0.ReadData1 : (s == 1) ? if0.ReadData2 : {31'b0, if0.Busy};
            1: v = (s == 0) ? if1.ReadData1 : (s == 1) ? if1.ReadData2 : {31'b0, if1.Busy};
            default: v = (s == 0) ? if2.ReadData1 : (s == 1) ? if2.ReadData2 : {31'b0, if2.Busy};
        endcase
        return v;
    endfunction

    function automatic string sname(input int s);
        return (s == 0) ? "ReadData1" : (s == 1) ? "ReadData2" : "Busy";
    endfunction

    always @(negedge Clock) begin
        exp_t        e;
        logic [31:0] act;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e   = q.pop_front();
            act = observe(e.dut, e.sig);
            n_cmp++;
            if (act !== e.exp || e.due != cyc) begin
                n_err++;
                $display("FAIL t%0d dut%0d %s cyc%0d: got %h expected %h",
                         e.tid, e.dut, sname(e.sig), cyc, act, e.exp);
            end
        end
    end

    task automatic drive(input int d, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic clr);
        case (d)
            0: begin
                if0.RegWrite = we; if0.WriteRegNo = wa; if0.WriteData = wd;
                if0.ReadReg1 = r1; if0.ReadReg2 = r2; if0.Clear = clr;
            end
            1: begin
                if1.RegWrite = we; if1.WriteRegNo = wa; if1.WriteData = wd;
                if1.ReadReg1 = r1; if1.ReadReg2 = r2; if1.Clear = clr;
            end
            default: begin
                if2.RegWrite = we; if2.WriteRegNo = wa; if2.WriteData = wd;
                if2.ReadReg1 = r1; if2.ReadReg2 = r2; if2.Clear = clr;
            end
        endcase
    endtask

    task automatic expect_rd(input int d, input logic [31:0] v1, input logic [31:0] v2,
                             input logic b, input int t);
        q.push_back('{d, 0, v1, cyc + 1, t});
        q.push_back('{d, 1, v2, cyc + 1, t});
        q.push_back('{d, 2, {31'b0, b}, cyc + 1, t});
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // Contents of the DEPTH=32 file while sweeping (r_a = a+1, r0 = 0): slot c = k-1 is cleared this edge.
    function automatic logic [31:0] sweep_exp(input int a, input int k);
        return (a <= k - 1) ? 32'd0 : 32'(a + 1);
    endfunction

    // Contents of the DEPTH=20 file after the fill: unmapped addresses and r0 read as zero.
    function automatic logic [31:0] d20_exp(input int a);
        return (a == 0 || a >= 20) ? 32'd0 : 32'(a + 1);
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        Reset = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) begin
            drive(d, 1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 1'b0);
            expect_rd(d, 32'd0, 32'd0, 1'b0, 0);
        end
        tick();
        Reset = 1'b1;

        // 1: everything reads zero after reset
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0);
            drive(2, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0);
            expect_rd(0, 32'd0, 32'd0, 1'b0, 1);
            expect_rd(2, 32'd0, 32'd0, 1'b0, 1);
            tick();
        end

        // 2: write r5, bypass on port 2, plain read on port 1 a cycle later
        drive(0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd5, 1'b0);
        expect_rd(0, 32'd0, 32'hDEADBEEF, 1'b0, 2);
        tick();
        drive(0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b0);
        expect_rd(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2);
        tick();

        // 3: r0 write, hardwired zero vs ordinary register
        drive(0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        drive(1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        expect_rd(0, 32'd0, 32'd0, 1'b0, 3);
        expect_rd(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3);
        tick();
        drive(0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        drive(1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        expect_rd(0, 32'd0, 32'd0, 1'b0, 3);
        expect_rd(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 3);
        tick();
        drive(1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);

        // 4: fill with index+1, then sweep
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b1, 5'(a), 32'(a + 1), 5'(a), 5'd5, 1'b0);
            expect_rd(0, (a == 0) ? 32'd0 : 32'(a + 1), (a < 5) ? 32'hDEADBEEF : 32'd6, 1'b0, 4);
            tick();
        end
        drive(0, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0, 1'b1);
        expect_rd(0, 32'd32, 32'd0, 1'b1, 4);
        tick();

        // 4/5: sweep edges; dropped write at k=2, mid-sweep reads and ignored Clear at k=11
        for (int k = 1; k <= 32; k++) begin
            int r1;
            int r2;
            r1 = (k == 11) ? 20 : (k == 2) ? 7 : 31;
            r2 = (k == 11) ? 3 : (k == 16) ? 15 : 30;
            drive(0, k == 2, 5'd7, 32'h1234, 5'(r1), 5'(r2), k == 11);
            expect_rd(0, sweep_exp(r1, k), sweep_exp(r2, k), k < 32, 5);
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            drive(0, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0);
            expect_rd(0, 32'd0, 32'd0, 1'b0, 4);
            tick();
        end
        drive(0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);

        // 6: DEPTH=20 build
        for (int a = 1; a < 20; a++) begin
            drive(2, 1'b1, 5'(a), 32'(a + 1), 5'(a), 5'd0, 1'b0);
            expect_rd(2, 32'(a + 1), 32'd0, 1'b0, 6);
            tick();
        end
        drive(2, 1'b1, 5'd25, 32'hA5, 5'd25, 5'd19, 1'b0);
        expect_rd(2, 32'd0, 32'd20, 1'b0, 6);
        tick();
        for (int a = 0; a < 32; a++) begin
            drive(2, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0);
            expect_rd(2, d20_exp(a), d20_exp(31 - a), 1'b0, 6);
            tick();
        end
        drive(2, 1'b0, 5'd0, 32'd0, 5'd19, 5'd25, 1'b1);
        expect_rd(2, 32'd20, 32'd0, 1'b1, 6);
        tick();
        for (int k = 1; k <= 8; k++) begin
            drive(2, 1'b0, 5'd0, 32'd0, 5'd19, 5'(k - 1), 1'b0);
            expect_rd(2, 32'd20, 32'd0, 1'b1, 6);
            tick();
        end
        // Short reset pulse between edges: only an asynchronous reset can see it
        drive(2, 1'b0, 5'd0, 32'd0, 5'd15, 5'd19, 1'b0);
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        expect_rd(2, 32'd0, 32'd0, 1'b0, 7);
        tick();
        for (int a = 0; a < 32; a++) begin
            drive(2, 1'b0, 5'd0, 32'd0, 5'(a), 5'(31 - a), 1'b0);
            expect_rd(2, 32'd0, 32'd0, 1'b0, 7);
            tick();
        end
        drive(2, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0);

        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations never checked, required 0", q.size());
            n_cmp += q.size();
            n_err += q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
